// File: rtl/multicycle_ctrl_if.sv
// Control/datapath bundle between the multicycle controller and its datapath.
// The slave modport is the controller side; master is the datapath/driver side.
interface multicycle_ctrl_if;
  logic [5:0] i_opcode;
  logic [5:0] i_funct;
  logic       i_zero;
  logic       o_pc_en;
  logic       o_iord;
  logic       o_mem_write;
  logic       o_ir_write;
  logic       o_reg_dst;
  logic       o_mem_to_reg;
  logic       o_reg_write;
  logic       o_alu_src_a;
  logic [1:0] o_alu_src_b;
  logic [1:0] o_pc_src;
  logic [3:0] o_alu_control;
  logic       o_illegal;
  logic [3:0] o_state;

  modport slave (
    input  i_opcode, i_funct, i_zero,
    output o_pc_en, o_iord, o_mem_write, o_ir_write, o_reg_dst, o_mem_to_reg,
           o_reg_write, o_alu_src_a, o_alu_src_b, o_pc_src, o_alu_control,
           o_illegal, o_state
  );

  modport master (
    output i_opcode, i_funct, i_zero,
    input  o_pc_en, o_iord, o_mem_write, o_ir_write, o_reg_dst, o_mem_to_reg,
           o_reg_write, o_alu_src_a, o_alu_src_b, o_pc_src, o_alu_control,
           o_illegal, o_state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style controller FSM (lw/sw/R-type/beq/j).
// Define MCTRL_ADDI_EN to add addi support through the ADDIEX/ADDIWB states.
module multicycle_ctrl (
  input  logic          i_clk,
  input  logic          i_rst,
  multicycle_ctrl_if.slave bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MCTRL_ADDI_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
`ifdef MCTRL_ADDI_EN
    , S_ADDIEX = 4'd10
    , S_ADDIWB = 4'd11
`endif
  } state_t;

  state_t state_q, state_d;

  logic       funct_ok;
  logic [3:0] funct_alu;
  state_t     decode_next;
  logic       decode_illegal;

  logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, illegal;
  logic [1:0] alu_src_b, pc_src;
  logic [3:0] alu_control, state_out;

  // NOTE: every signal assigned in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (bus.i_funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b100111: funct_alu = ALU_NOR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_ok  = 1'b0;
    endcase
  end

  // Unsupported opcodes and R-type functs fall back to FETCH and flag illegal.
  always_comb begin
    decode_next    = S_FETCH;
    decode_illegal = 1'b0;
    case (bus.i_opcode)
      OP_LW, OP_SW: decode_next = S_MEMADR;
      OP_RTYPE: begin
        if (funct_ok) decode_next    = S_EXEC;
        else          decode_illegal = 1'b1;
      end
      OP_BEQ:  decode_next = S_BRANCH;
      OP_J:    decode_next = S_JUMP;
`ifdef MCTRL_ADDI_EN
      OP_ADDI: decode_next = S_ADDIEX;
`endif
      default: decode_illegal = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = decode_next;
      S_MEMADR: state_d = (bus.i_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_ALUWB;
`ifdef MCTRL_ADDI_EN
      S_ADDIEX: state_d = S_ADDIWB;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  // Reset overrides the FETCH decode so nothing is enabled while i_rst is high.
  always_comb begin
    pc_en       = 1'b0;
    iord        = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    pc_src      = 2'b00;
    alu_control = ALU_AND;
    illegal     = 1'b0;
    state_out   = 4'd0;
    if (!i_rst) begin
      state_out = state_q;
      case (state_q)
        S_FETCH: begin
          ir_write    = 1'b1;
          alu_src_b   = 2'b01;
          alu_control = ALU_ADD;
          pc_en       = 1'b1;
        end
        S_DECODE: begin
          alu_src_b   = 2'b11;
          alu_control = ALU_ADD;
          illegal     = decode_illegal;
        end
        S_MEMADR: begin
          alu_src_a   = 1'b1;
          alu_src_b   = 2'b10;
          alu_control = ALU_ADD;
        end
        S_MEMRD: iord = 1'b1;
        S_MEMWB: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
        end
        S_MEMWR: begin
          iord      = 1'b1;
          mem_write = 1'b1;
        end
        S_EXEC: begin
          alu_src_a   = 1'b1;
          alu_control = funct_alu;
        end
        S_ALUWB: begin
          reg_dst   = 1'b1;
          reg_write = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a   = 1'b1;
          alu_control = ALU_SUB;
          pc_src      = 2'b01;
          pc_en       = bus.i_zero;
        end
        S_JUMP: begin
          pc_src = 2'b10;
          pc_en  = 1'b1;
        end
`ifdef MCTRL_ADDI_EN
        S_ADDIEX: begin
          alu_src_a   = 1'b1;
          alu_src_b   = 2'b10;
          alu_control = ALU_ADD;
        end
        S_ADDIWB: reg_write = 1'b1;
`endif
        default: ;
      endcase
    end
  end

  assign bus.o_pc_en       = pc_en;
  assign bus.o_iord        = iord;
  assign bus.o_mem_write   = mem_write;
  assign bus.o_ir_write    = ir_write;
  assign bus.o_reg_dst     = reg_dst;
  assign bus.o_mem_to_reg  = mem_to_reg;
  assign bus.o_reg_write   = reg_write;
  assign bus.o_alu_src_a   = alu_src_a;
  assign bus.o_alu_src_b   = alu_src_b;
  assign bus.o_pc_src      = pc_src;
  assign bus.o_alu_control = alu_control;
  assign bus.o_illegal     = illegal;
  assign bus.o_state       = state_out;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Table-driven bench for multicycle_ctrl: per-cycle input/expected-output records,
// plus a hand-written reset-during-MEMRD sequence.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       pc_en;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [3:0] alu_control;
    logic       illegal;
    logic [3:0] state;
  } outs_t;

  typedef struct {
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    outs_t      exp;
  } vec_t;

  localparam logic [5:0] RT = 6'b000000;
  localparam logic [5:0] LW = 6'b100011;
  localparam logic [5:0] SW = 6'b101011;
  localparam logic [5:0] BQ = 6'b000100;
  localparam logic [5:0] JP = 6'b000010;
  localparam logic [5:0] AI = 6'b001000;

  //                                pc  io  mw  ir  rd  m2r rw  sa  srcb   pcsrc  alu      ill state
  localparam outs_t E_RST    = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,4'b0000,1'b0,4'd0};
  localparam outs_t E_FETCH  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,4'b0010,1'b0,4'd0};
  localparam outs_t E_DEC    = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,4'b0010,1'b0,4'd1};
  localparam outs_t E_DECILL = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,4'b0010,1'b1,4'd1};
  localparam outs_t E_MEMADR = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,4'b0010,1'b0,4'd2};
  localparam outs_t E_MEMRD  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,4'b0000,1'b0,4'd3};
  localparam outs_t E_MEMWB  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,4'b0000,1'b0,4'd4};
  localparam outs_t E_MEMWR  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,4'b0000,1'b0,4'd5};
  localparam outs_t E_ALUWB  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,4'b0000,1'b0,4'd7};
  localparam outs_t E_BRT    = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,4'b0110,1'b0,4'd8};
  localparam outs_t E_BRNT   = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,4'b0110,1'b0,4'd8};
  localparam outs_t E_JUMP   = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,4'b0000,1'b0,4'd9};
  localparam outs_t E_ADDIEX = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,4'b0010,1'b0,4'd10};
  localparam outs_t E_ADDIWB = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,4'b0000,1'b0,4'd11};

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  int    n_vec = 0;
  int    n_err = 0;
  vec_t  vecs[$];
  outs_t act;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign act = {bus.o_pc_en, bus.o_iord, bus.o_mem_write, bus.o_ir_write, bus.o_reg_dst,
                bus.o_mem_to_reg, bus.o_reg_write, bus.o_alu_src_a, bus.o_alu_src_b,
                bus.o_pc_src, bus.o_alu_control, bus.o_illegal, bus.o_state};

  function automatic outs_t e_exec(input logic [3:0] alu);
    outs_t e;
    e = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,4'b0000,1'b0,4'd6};
    e.alu_control = alu;
    return e;
  endfunction

  task automatic check(input string name, input outs_t got, input outs_t exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h (state %0d) expected %h (state %0d)",
               name, got, got.state, exp, exp.state);
    end
  endtask

  task automatic add(input logic [5:0] op, input logic [5:0] f, input logic z, input outs_t e);
    vecs.push_back('{opcode: op, funct: f, zero: z, exp: e});
  endtask

  task automatic add_rtype(input logic [5:0] f, input logic [3:0] alu);
    add(RT, f, 1'b0, E_FETCH);
    add(RT, f, 1'b0, E_DEC);
    add(RT, f, 1'b0, e_exec(alu));
    add(RT, f, 1'b0, E_ALUWB);
  endtask

  // Drive one cycle's inputs, check the combinational outputs, then step one clock.
  task automatic apply(input string name, input logic [5:0] op, input logic [5:0] f,
                       input logic z, input outs_t e);
    bus.i_opcode = op;
    bus.i_funct  = f;
    bus.i_zero   = z;
    #1;
    check(name, act, e);
    @(posedge clk);
    #2;
  endtask

  initial begin
    bus.i_opcode = 6'b111111;
    bus.i_funct  = 6'b000000;
    bus.i_zero   = 1'b0;

    // lw: 5 cycles
    add(LW, 6'd0, 1'b0, E_FETCH);
    add(LW, 6'd0, 1'b0, E_DEC);
    add(LW, 6'd0, 1'b0, E_MEMADR);
    add(LW, 6'd0, 1'b0, E_MEMRD);
    add(LW, 6'd0, 1'b0, E_MEMWB);
    // sw: 4 cycles
    add(SW, 6'd0, 1'b0, E_FETCH);
    add(SW, 6'd0, 1'b0, E_DEC);
    add(SW, 6'd0, 1'b0, E_MEMADR);
    add(SW, 6'd0, 1'b0, E_MEMWR);
    // R-type, every supported funct
    add_rtype(6'b101010, 4'b0111);
    add_rtype(6'b100000, 4'b0010);
    add_rtype(6'b100010, 4'b0110);
    add_rtype(6'b100100, 4'b0000);
    add_rtype(6'b100101, 4'b0001);
    add_rtype(6'b100111, 4'b1100);
    // R-type with unsupported funct: illegal pulse then FETCH
    add(RT, 6'b000001, 1'b0, E_FETCH);
    add(RT, 6'b000001, 1'b0, E_DECILL);
    // beq taken / not taken
    add(BQ, 6'd0, 1'b1, E_FETCH);
    add(BQ, 6'd0, 1'b1, E_DEC);
    add(BQ, 6'd0, 1'b1, E_BRT);
    add(BQ, 6'd0, 1'b0, E_FETCH);
    add(BQ, 6'd0, 1'b0, E_DEC);
    add(BQ, 6'd0, 1'b0, E_BRNT);
    // j
    add(JP, 6'd0, 1'b0, E_FETCH);
    add(JP, 6'd0, 1'b0, E_DEC);
    add(JP, 6'd0, 1'b0, E_JUMP);
    // unsupported opcode 111111, twice back-to-back
    add(6'b111111, 6'b100000, 1'b0, E_FETCH);
    add(6'b111111, 6'b100000, 1'b0, E_DECILL);
    add(6'b111111, 6'b100000, 1'b0, E_FETCH);
    add(6'b111111, 6'b100000, 1'b0, E_DECILL);
    // addi
    add(AI, 6'd0, 1'b0, E_FETCH);
`ifdef MCTRL_ADDI_EN
    add(AI, 6'd0, 1'b0, E_DEC);
    add(AI, 6'd0, 1'b0, E_ADDIEX);
    add(AI, 6'd0, 1'b0, E_ADDIWB);
`else
    add(AI, 6'd0, 1'b0, E_DECILL);
`endif

    // Reset state, before and across a clock edge
    #2;
    check("reset_hold", act, E_RST);
    @(posedge clk);
    #2;
    check("reset_after_edge", act, E_RST);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i])
      apply($sformatf("vec%0d_op%b", i, vecs[i].opcode), vecs[i].opcode, vecs[i].funct,
            vecs[i].zero, vecs[i].exp);

    // Reset pulse during MEMRD of an lw aborts it with no register write
    apply("rst_lw_fetch",  LW, 6'd0, 1'b0, E_FETCH);
    apply("rst_lw_decode", LW, 6'd0, 1'b0, E_DEC);
    apply("rst_lw_memadr", LW, 6'd0, 1'b0, E_MEMADR);
    #1;
    check("rst_lw_memrd", act, E_MEMRD);
    #1;
    rst = 1'b1;
    #1;
    check("rst_async_mid_memrd", act, E_RST);
    @(posedge clk);
    #2;
    check("rst_held_no_wb", act, E_RST);
    @(negedge clk);
    rst = 1'b0;
    apply("post_rst_fetch",  JP, 6'd0, 1'b0, E_FETCH);
    apply("post_rst_decode", JP, 6'd0, 1'b0, E_DEC);
    apply("post_rst_jump",   JP, 6'd0, 1'b0, E_JUMP);
    apply("post_rst_refetch", LW, 6'd0, 1'b0, E_FETCH);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL: i_clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: i_rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL: i_opcode  input  6  instruction opcode from external IR; sampled in DECODE.
REQ-004 SHALL: i_funct  input  6  R-type funct from external IR; used in EXEC.
REQ-005 SHALL: i_zero  input  1  external zero flag of the ALU result; used in BRANCH.
REQ-006 SHALL: o_pc_en  output  1  PC load enable.
REQ-007 SHALL: o_iord, o_mem_write, o_ir_write, o_reg_dst, o_mem_to_reg, o_reg_write, o_alu_src_a  output  1 each  datapath selects/enables.
REQ-008 SHALL: o_alu_src_b  output  2  ALU operand B select: 00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2.
REQ-009 SHALL: o_pc_src  output  2  PC source: 00 ALU result, 01 ALUOut register, 10 jump target.
REQ-010 SHALL: o_alu_control  output  4  ALU op: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.
REQ-011 SHALL: o_illegal  output  1  one-cycle pulse on an unsupported opcode or funct.
REQ-012 SHALL: o_state  output  4  current state encoding, for debug.

Function
REQ-013 SHALL: State encoding is FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11.
REQ-014 SHALL: All outputs are combinational from the state (plus i_funct in EXEC, i_zero in BRANCH, i_opcode/i_funct in DECODE); every output not listed for a state is 0.
REQ-015 SHALL: FETCH drives o_ir_write=1, o_alu_src_b=01, o_alu_control=ADD, o_pc_src=00, o_pc_en=1, then goes to DECODE.
REQ-016 SHALL: DECODE drives o_alu_src_b=11 and ADD; next state by opcode: 100011/101011->MEMADR, 000000->EXEC, 000100->BRANCH, 000010->JUMP, 001000->ADDIEX (macro permitting), otherwise FETCH.
REQ-017 SHALL: In DECODE, opcode 000000 with a funct outside {100000 add, 100010 sub, 100100 and, 100101 or, 100111 nor, 101010 slt} goes to FETCH.
REQ-018 SHALL: o_illegal=1 only in DECODE and only when the next state is FETCH because of REQ-016 or REQ-017.
REQ-019 SHALL: MEMADR drives o_alu_src_a=1, o_alu_src_b=10, ADD; goes to MEMRD for 100011, else MEMWR.
REQ-020 SHALL: MEMRD drives o_iord=1, then MEMWB; MEMWB drives o_mem_to_reg=1, o_reg_write=1, o_reg_dst=0, then FETCH.
REQ-021 SHALL: MEMWR drives o_iord=1, o_mem_write=1, then FETCH.
REQ-022 SHALL: EXEC drives o_alu_src_a=1, o_alu_src_b=00, and o_alu_control mapped from funct (add->0010, sub->0110, and->0000, or->0001, nor->1100, slt->0111), then ALUWB.
REQ-023 SHALL: ALUWB drives o_reg_dst=1, o_reg_write=1, o_mem_to_reg=0, then FETCH.
REQ-024 SHALL: BRANCH drives o_alu_src_a=1, o_alu_src_b=00, SUB, o_pc_src=01, o_pc_en=i_zero, then FETCH.
REQ-025 SHALL: JUMP drives o_pc_src=10, o_pc_en=1, then FETCH.
REQ-026 SHALL: Cycles per instruction are lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, and 2 for an illegal instruction.
REQ-027 SHALL: o_mem_write and o_reg_write never assert in the same cycle, and each asserts at most once per instruction.

Reset
REQ-028 SHALL: Asserting i_rst forces FETCH immediately, asynchronously, including mid-instruction; the aborted instruction issues no further writes.
REQ-029 SHALL: While i_rst=1, all outputs are 0 (o_pc_en=0, o_ir_write=0, o_state=0), overriding FETCH decode.
REQ-030 SHALL: After i_rst deasserts, the first rising edge performs a normal FETCH cycle.

Configuration
REQ-031 SHALL: With macro MCTRL_ADDI_EN defined, opcode 001000 goes DECODE->ADDIEX->ADDIWB->FETCH.
REQ-032 SHALL: ADDIEX drives o_alu_src_a=1, o_alu_src_b=10, ADD; ADDIWB drives o_reg_dst=0, o_mem_to_reg=0, o_reg_write=1.
REQ-033 SHALL: Without MCTRL_ADDI_EN, states 10/11 are absent and opcode 001000 is illegal per REQ-018.

Verification
REQ-034 SHALL: lw (100011) after reset -> o_state sequence 0,1,2,3,4,0; o_reg_write=1 and o_mem_to_reg=1 only in state 4.
REQ-035 SHALL: R-type funct 101010 -> o_alu_control=0111 in EXEC; o_reg_dst=1 and o_reg_write=1 in ALUWB; 4 cycles.
REQ-036 SHALL: beq with i_zero=1 -> o_pc_en=1, o_pc_src=01 in BRANCH; with i_zero=0 -> o_pc_en=0; 3 cycles.
REQ-037 SHALL: opcode 111111 -> o_illegal=1 for exactly one cycle in DECODE, then FETCH.
REQ-038 SHALL: i_rst pulse during MEMRD -> o_state=0 before the next edge, no o_reg_write for that lw.
REQ-039 SHALL: opcode 001000 -> with MCTRL_ADDI_EN states 0,1,10,11,0; without it, o_illegal=1 and return to 0.
